imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Two-port arbiter that shares the single-read-port, one-cycle-latency instruction memory between the core fetch unit (port 0) and the debug/loader read path (port 1). Each cycle it grants at most one requester using round-robin priority and drives the memory read. It tags the access so the registered memory output returns to the correct owner the following cycle. Misaligned and out-of-range addresses are rejected without a memory access, and port 0 supports a fetch flush for redirects.

## Interface

- MEM_WORDS, 1024, instruction memory depth in 32-bit words; byte-address limit is MEM_WORDS*4.
- ADDR_W, 32, requester byte-address width.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req0 / req1  input  1  request from port 0 (fetch) / port 1 (debug).
- addr0 / addr1  input  ADDR_W  byte address of the request.
- flush0  input  1  port-0 redirect: squash the in-flight port-0 response and block a port-0 grant this cycle.
- gnt0 / gnt1  output  1  request accepted this cycle (combinational).
- rvalid0 / rvalid1  output  1  response valid, one-cycle pulse.
- rdata0 / rdata1  output  32  response word; 0 when err or not valid.
- err0 / err1  output  1  response is an address error; meaningful only with rvalid.
- mem_rd  output  1  memory read enable.
- mem_addr  output  ADDR_W  byte address to memory. The memory indexes word addr[11:2].
- mem_instr  input  32  memory read data, registered one cycle after mem_rd.

## Operation

- **Handshake:** a requester holds req and addr stable until it sees gnt. The grant completes in the cycle gnt=1, and the requester may present a new request next cycle.
- **Arbitration:** round-robin with a 1-bit last-granted pointer `last`.
  - Only one requester eligible: that requester is granted.
  - Both eligible: the port that is not `last` is granted.
  - `last` updates on every grant.
  - Reset value of `last` is 1, so port 0 wins the first conflict.
- **Eligibility:** port 0 is eligible when req0 && !flush0. Port 1 is eligible when req1.
- **Address check** on the granted address:
  - ok = (addr[1:0]==0) && (addr < MEM_WORDS*4).
  - ok: mem_rd=1 and mem_addr=granted addr.
  - Not ok: mem_rd=0, and an error response is scheduled.
- **Response tag register,** captured each cycle: {valid, port, err} = {any grant, granted port, !ok}.
- **Response cycle** (next cycle): rvalid of the tagged port = 1.
  - err set: rdata=0 and err=1.
  - Otherwise: rdata=mem_instr and err=0.
  - The non-tagged port has rvalid=0 and rdata=0.
- **Flush:** if flush0=1 in the response cycle of a port-0 tag, rvalid0 is forced 0 and that response is dropped, including error responses. A port-1 response is unaffected by flush0.
- No grant: mem_rd=0, mem_addr=0, tag valid=0.

## Timing

- Reset values:
  - gnt0/gnt1 = 0 (forced while rst_n=0).
  - rvalid0/rvalid1 = 0, rdata0/rdata1 = 0, err0/err1 = 0.
  - mem_rd = 0, mem_addr = 0.
  - Tag valid = 0, `last` = 1.
- Latency is fixed: grant in cycle N, rvalid in cycle N+1. There is no response back-pressure, so the requester must accept the response.
- Throughput is one access per cycle. With req0 and req1 held continuously, grants alternate 0,1,0,1.
- Simultaneous grant and response in the same cycle is normal pipelined operation, and the two are independent.
- Reset mid-operation: the in-flight tag clears asynchronously and no response is delivered after rst_n rises. The first post-reset conflict goes to port 0.
- Boundaries:
  - addr = MEM_WORDS*4-4 is valid.
  - addr = MEM_WORDS*4 is an error.
  - addr = 0xFFFFFFFC is an error and must not alias.
- gnt, mem_rd and mem_addr are combinational from req, addr, flush0 and `last`. rvalid, rdata and err are combinational from the tag register and mem_instr.

## Test plan

- **Single fetch:** req0=1, addr0=0x8 at cycle N, preloaded imem[2]=0x00A00093.
  - Cycle N: gnt0=1, mem_rd=1, mem_addr=0x8.
  - Cycle N+1: rvalid0=1, rdata0=0x00A00093, err0=0, rvalid1=0.
- **Contention:** req0=req1=1 held for 4 cycles from reset, addr0=0x0, addr1=0x4.
  - Grants in order 0,1,0,1.
  - Each response arrives on the matching port one cycle later with the correct word.
- **Address errors:**
  - addr1=0x6: gnt1=1, mem_rd=0; next cycle rvalid1=1, err1=1, rdata1=0.
  - addr1=0x1000: same response, err1=1.
  - addr1=0xFFC: normal read with err1=0.
- **Flush:**
  - req0 granted at 0x10 in cycle N, flush0=1 in N+1: no rvalid0 in N+1, and a req0 present in N+1 is not granted.
  - If req1 is also present in N+1, it is granted.
- **Reset mid-flight:** grant port 1 in cycle N, assert rst_n=0 before edge N+1.
  - No rvalid1 is seen, and all outputs are 0.
  - After release, a contending req0/req1 pair grants port 0 first.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: requester, flush and instruction-memory signals of the arbiter
interface imem_arbiter_if #(parameter int ADDR_W = 32);
  logic              req0, req1, flush0;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1, err0, err1;
  logic [31:0]       rdata0, rdata1;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_instr;
  modport master (
    output req0, req1, addr0, addr1, flush0, mem_instr,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1, mem_rd, mem_addr
  );
  modport slave (
    input  req0, req1, addr0, addr1, flush0, mem_instr,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1, mem_rd, mem_addr
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin sharing of a one-cycle-latency imem between fetch and debug ports
module imem_arbiter #(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 32
) (
  input logic           clk,
  input logic           rst_n,
  imem_arbiter_if.slave bus
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_WORDS * 4);
  logic              r_last, r_tag_vld, r_tag_port, r_tag_err;
  logic              w_elig0, w_elig1, w_gnt0, w_gnt1, w_any, w_ok, w_rv0, w_rv1;
  logic [ADDR_W-1:0] w_addr;
  // Grant, address check and memory drive; the wide compare keeps high addresses from aliasing
  always_comb begin
    w_elig0 = bus.req0 & ~bus.flush0;
    w_elig1 = bus.req1;
    w_gnt0  = rst_n & w_elig0 & (~w_elig1 | r_last);
    w_gnt1  = rst_n & w_elig1 & (~w_elig0 | ~r_last);
    w_any   = w_gnt0 | w_gnt1;
    w_addr  = w_gnt1 ? bus.addr1 : bus.addr0;
    w_ok    = (w_addr[1:0] == 2'b00) && ({1'b0, w_addr} < LIMIT);
    w_rv0   = r_tag_vld & ~r_tag_port & ~bus.flush0;
    w_rv1   = r_tag_vld & r_tag_port;
  end
  assign bus.gnt0     = w_gnt0;
  assign bus.gnt1     = w_gnt1;
  assign bus.mem_rd   = w_any & w_ok;
  assign bus.mem_addr = (w_any & w_ok) ? w_addr : '0;
  assign bus.rvalid0  = w_rv0;
  assign bus.rvalid1  = w_rv1;
  assign bus.err0     = w_rv0 & r_tag_err;
  assign bus.err1     = w_rv1 & r_tag_err;
  assign bus.rdata0   = (w_rv0 & ~r_tag_err) ? bus.mem_instr : 32'h0;
  assign bus.rdata1   = (w_rv1 & ~r_tag_err) ? bus.mem_instr : 32'h0;
  // Response tag and round-robin pointer; pointer only moves when someone is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= 1'b1;
      r_tag_vld  <= 1'b0;
      r_tag_port <= 1'b0;
      r_tag_err  <= 1'b0;
    end else begin
      if (w_any) r_last <= w_gnt1;
      r_tag_vld  <= w_any;
      r_tag_port <= w_gnt1;
      r_tag_err  <= ~w_ok;
    end
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed vector table plus reset-mid-flight sequence for imem_arbiter
module tb_imem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] mem [0:1023];

  imem_arbiter_if #(.ADDR_W(32)) bus ();
  imem_arbiter #(.MEM_WORDS(1024), .ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // memory model: registered read, one cycle after mem_rd
  always @(posedge clk) if (bus.mem_rd) bus.mem_instr <= mem[bus.mem_addr[11:2]];

  typedef struct {
    logic        r0, r1;
    logic [31:0] a0, a1;
    logic        f;
    logic [6:0]  flags;
    logic [31:0] ma, d0, d1;
  } vec_t;
  vec_t tbl [20];

  function automatic logic [6:0] flags_now();
    return {bus.gnt0, bus.gnt1, bus.mem_rd, bus.rvalid0, bus.rvalid1, bus.err0, bus.err1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [6:0] f, input logic [31:0] ma,
                         input logic [31:0] d0, input logic [31:0] d1);
    chk({tag, " flags{g0,g1,rd,v0,v1,e0,e1}"}, 32'(flags_now()), 32'(f));
    chk({tag, " mem_addr"}, bus.mem_addr, ma);
    chk({tag, " rdata0"}, bus.rdata0, d0);
    chk({tag, " rdata1"}, bus.rdata1, d1);
  endtask

  task automatic drive(input logic r0, input logic r1, input logic [31:0] a0,
                       input logic [31:0] a1, input logic f);
    bus.req0 = r0; bus.req1 = r1; bus.addr0 = a0; bus.addr1 = a1; bus.flush0 = f;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 + i;
    mem[2]    = 32'h00A0_0093;
    mem[1023] = 32'hDEAD_BEEF;
    bus.mem_instr = 32'h0;
    tbl[0]  = '{0, 0, 32'h0,  32'h0,         0, 7'b0000000, 32'h0,   32'h0,          32'h0};
    tbl[1]  = '{1, 1, 32'h0,  32'h4,         0, 7'b1010000, 32'h0,   32'h0,          32'h0};
    tbl[2]  = '{1, 1, 32'h0,  32'h4,         0, 7'b0111000, 32'h4,   32'hC000_0000,  32'h0};
    tbl[3]  = '{1, 1, 32'h0,  32'h4,         0, 7'b1010100, 32'h0,   32'h0,          32'hC000_0001};
    tbl[4]  = '{1, 1, 32'h0,  32'h4,         0, 7'b0111000, 32'h4,   32'hC000_0000,  32'h0};
    tbl[5]  = '{1, 0, 32'h8,  32'h0,         0, 7'b1010100, 32'h8,   32'h0,          32'hC000_0001};
    tbl[6]  = '{0, 1, 32'h0,  32'h6,         0, 7'b0101000, 32'h0,   32'h00A0_0093,  32'h0};
    tbl[7]  = '{0, 1, 32'h0,  32'h1000,      0, 7'b0100101, 32'h0,   32'h0,          32'h0};
    tbl[8]  = '{0, 1, 32'h0,  32'hFFC,       0, 7'b0110101, 32'hFFC, 32'h0,          32'h0};
    tbl[9]  = '{0, 1, 32'h0,  32'hFFFF_FFFC, 0, 7'b0100100, 32'h0,   32'h0,          32'hDEAD_BEEF};
    tbl[10] = '{0, 0, 32'h0,  32'h0,         0, 7'b0000101, 32'h0,   32'h0,          32'h0};
    tbl[11] = '{1, 0, 32'h10, 32'h0,         0, 7'b1010000, 32'h10,  32'h0,          32'h0};
    tbl[12] = '{1, 1, 32'h14, 32'h8,         1, 7'b0110000, 32'h8,   32'h0,          32'h0};
    tbl[13] = '{0, 0, 32'h0,  32'h0,         0, 7'b0000100, 32'h0,   32'h0,          32'h00A0_0093};
    tbl[14] = '{1, 0, 32'h10, 32'h0,         0, 7'b1010000, 32'h10,  32'h0,          32'h0};
    tbl[15] = '{0, 0, 32'h0,  32'h0,         0, 7'b0001000, 32'h0,   32'hC000_0004,  32'h0};
    tbl[16] = '{1, 0, 32'h3,  32'h0,         0, 7'b1000000, 32'h0,   32'h0,          32'h0};
    tbl[17] = '{0, 0, 32'h0,  32'h0,         1, 7'b0000000, 32'h0,   32'h0,          32'h0};
    tbl[18] = '{0, 1, 32'h0,  32'h0,         0, 7'b0110000, 32'h0,   32'h0,          32'h0};
    tbl[19] = '{0, 0, 32'h0,  32'h0,         1, 7'b0000100, 32'h0,   32'h0,          32'hC000_0000};
    drive(1, 1, 32'h0, 32'h4, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 7'b0000000, 32'h0, 32'h0, 32'h0);
    drive(0, 0, 32'h0, 32'h0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].r0, tbl[i].r1, tbl[i].a0, tbl[i].a1, tbl[i].f);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i].flags, tbl[i].ma, tbl[i].d0, tbl[i].d1);
    end
    @(posedge clk); #1;
    drive(0, 1, 32'h0, 32'h4, 0);
    @(negedge clk);
    chk_all("midflight grant", 7'b0110000, 32'h4, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    drive(1, 1, 32'h0, 32'h4, 0);
    #1 chk_all("in reset", 7'b0000000, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk_all("in reset after edge", 7'b0000000, 32'h0, 32'h0, 32'h0);
    drive(0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1, 1, 32'h0, 32'h4, 0);
    @(negedge clk);
    chk_all("post reset conflict", 7'b1010000, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk_all("post reset response", 7'b0001000, 32'h0, 32'hC000_0000, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
